mpsoc_wb_uart_tfifo: RTL and testbench

MPSOC_WB_UART_TFIFO -- requirements
Module: mpsoc_wb_uart_tfifo

---
 rtl/mpsoc_wb_uart_tfifo_pkg.sv | 10 +
 rtl/mpsoc_wb_raminfr.sv | 24 ++
 rtl/mpsoc_wb_uart_tfifo.sv | 72 +++++++
 tb/tb_mpsoc_wb_uart_tfifo.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mpsoc_wb_uart_tfifo_pkg.sv
// Shared defaults for the UART transmit/receive FIFOs.
// Word width, depth and the pointer/counter widths derived from the depth.
package mpsoc_wb_uart_tfifo_pkg;

  localparam int DEF_FIFO_WIDTH     = 8;
  localparam int DEF_FIFO_DEPTH     = 16;
  localparam int DEF_FIFO_POINTER_W = 4;
  localparam int DEF_FIFO_COUNTER_W = DEF_FIFO_POINTER_W + 1;

endpackage

// File: rtl/mpsoc_wb_raminfr.sv
// Inferred dual-port RAM for the UART FIFOs.
// Synchronous write port and asynchronous read port; the contents are never reset.
module mpsoc_wb_raminfr #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [ADDR_WIDTH-1:0] dpra,
  input  logic [DATA_WIDTH-1:0] di,
  output logic [DATA_WIDTH-1:0] dpo
);

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (we) ram[a] <= di;
  end

  assign dpo = ram[dpra];

endmodule

// File: rtl/mpsoc_wb_uart_tfifo.sv
// UART FIFO: circular buffer with occupancy count, full/empty flags and a sticky overrun flag.
// A push into a full FIFO is accepted only when a pop is in the same cycle, which frees the slot being written.
module mpsoc_wb_uart_tfifo
  import mpsoc_wb_uart_tfifo_pkg::*;
#(
  parameter int FIFO_WIDTH     = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int FIFO_POINTER_W = DEF_FIFO_POINTER_W,
  parameter int FIFO_COUNTER_W = DEF_FIFO_COUNTER_W
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic [FIFO_WIDTH-1:0]     data_in,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      fifo_reset,
  input  logic                      reset_status,
  output logic [FIFO_WIDTH-1:0]     data_out,
  output logic [FIFO_COUNTER_W-1:0] count,
  output logic                      full,
  output logic                      empty,
  output logic                      overrun
);

  logic [FIFO_POINTER_W-1:0] top;
  logic [FIFO_POINTER_W-1:0] bottom;
  logic                      push_ok;
  logic                      pop_ok;
  logic                      overrun_set;

  assign full  = (count == FIFO_COUNTER_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign push_ok     = push & (~full | pop);
  assign pop_ok      = pop & ~empty;
  assign overrun_set = push & full & ~pop;

  mpsoc_wb_raminfr #(
    .ADDR_WIDTH (FIFO_POINTER_W),
    .DATA_WIDTH (FIFO_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (push_ok & ~fifo_reset),
    .a    (top),
    .dpra (bottom),
    .di   (data_in),
    .dpo  (data_out)
  );

  // fifo_reset flushes bookkeeping only; stored words stay but become unreachable.
  always_ff @(posedge clk) begin
    if (wb_rst_i || fifo_reset) begin
      top     <= '0;
      bottom  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) top    <= top + FIFO_POINTER_W'(1);
      if (pop_ok)  bottom <= bottom + FIFO_POINTER_W'(1);
      if (push_ok && !pop_ok)
        count <= count + FIFO_COUNTER_W'(1);
      else if (pop_ok && !push_ok)
        count <= count - FIFO_COUNTER_W'(1);
      if (overrun_set)
        overrun <= 1'b1;
      else if (reset_status)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mpsoc_wb_uart_tfifo.sv
// Scoreboard bench for mpsoc_wb_uart_tfifo: expected words queued on accepted push, compared on pop.
// Flags and count follow a small reference model of the FIFO bookkeeping.
module tb_mpsoc_wb_uart_tfifo;

  logic       clk = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic [7:0] data_in = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       fifo_reset = 1'b0;
  logic       reset_status = 1'b0;
  logic [7:0] data_out;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overrun;

  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] sb [$];
  logic       m_ovr = 1'b0;

  mpsoc_wb_uart_tfifo dut (
    .clk          (clk),
    .wb_rst_i     (wb_rst_i),
    .data_in      (data_in),
    .push         (push),
    .pop          (pop),
    .fifo_reset   (fifo_reset),
    .reset_status (reset_status),
    .data_out     (data_out),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("count", 32'(count), 32'(sb.size()));
    check("empty", 32'(empty), 32'(sb.size() == 0));
    check("full", 32'(full), 32'(sb.size() == 16));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (sb.size() > 0) check("head", 32'(data_out), 32'(sb[0]));
  endtask

  // One clock cycle of stimulus, driven just after a falling edge.
  task automatic step(input logic p, input logic q, input logic [7:0] d,
                      input logic fr, input logic rs);
    bit pa, pp, ovs;
    push = p; pop = q; data_in = d; fifo_reset = fr; reset_status = rs;
    #1;
    pa  = p && (sb.size() < 16 || q);
    pp  = q && sb.size() > 0;
    ovs = p && sb.size() == 16 && !q;
    if (!fr && pp) check("pop_data", 32'(data_out), 32'(sb[0]));
    @(posedge clk);
    if (fr) begin
      sb.delete();
      m_ovr = 1'b0;
    end else begin
      if (pp) void'(sb.pop_front());
      if (pa) sb.push_back(d);
      if (ovs) m_ovr = 1'b1;
      else if (rs) m_ovr = 1'b0;
    end
    @(negedge clk);
    push = 0; pop = 0; fifo_reset = 0; reset_status = 0;
    check_state();
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    push = 1'b1; pop = 1'b1; fifo_reset = 1'b0; reset_status = 1'b0; data_in = 8'h77;
    @(posedge clk);
    @(negedge clk);
    wb_rst_i = 1'b0; push = 0; pop = 0;
    sb.delete();
    m_ovr = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    step(1, 0, 8'hA5, 0, 0);
    check("a5_dout", 32'(data_out), 32'hA5);
    check("a5_count", 32'(count), 32'd1);
    check("a5_empty", 32'(empty), 32'd0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    check("pop_empty_cnt", 32'(count), 32'd0);

    for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0, 0);
    step(1, 0, 8'hFF, 0, 0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_overrun", 32'(overrun), 32'd1);
    step(0, 0, 8'h00, 0, 1);
    check("rs_overrun", 32'(overrun), 32'd0);
    check("rs_count", 32'(count), 32'd16);
    step(1, 0, 8'hEE, 0, 1);
    check("rs_set_wins", 32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0, 0);
    check("drain_empty", 32'(empty), 32'd1);
    check("sticky_ovr", 32'(overrun), 32'd1);

    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h80 + i), 0, 0);
    check("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0, 0);
    check("wrap_empty", 32'(empty), 32'd1);

    step(1, 1, 8'h3C, 0, 0);
    check("pp0_count", 32'(count), 32'd1);
    check("pp0_dout", 32'(data_out), 32'h3C);
    for (int i = 0; i < 15; i++) step(1, 0, 8'(8'hC0 + i), 0, 0);
    step(1, 1, 8'h5A, 0, 0);
    check("ppf_count", 32'(count), 32'd16);
    check("ppf_overrun", 32'(overrun), 32'd0);

    step(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h20 + i), 0, 0);
    check("pre_fr_count", 32'(count), 32'd7);
    step(1, 0, 8'h11, 1, 0);
    check("fr_count", 32'(count), 32'd0);
    check("fr_empty", 32'(empty), 32'd1);
    check("fr_overrun", 32'(overrun), 32'd0);
    step(1, 0, 8'h22, 0, 0);
    check("fr_newhead", 32'(data_out), 32'h22);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
           8'($urandom), 1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 5));

    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h60 + i), 0, 0);
    do_reset();
    check("midrst_empty", 32'(empty), 32'd1);
    step(1, 0, 8'h99, 0, 0);
    check("midrst_head", 32'(data_out), 32'h99);
    check("midrst_count", 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
